surfturf_cmdq_core: RTL and testbench

Parametrised Wishbone-to-AXI4-Stream command queue for the SURF/TURF link, generalising the fixed runcmd/trigger holding registers into NUM_CH independent channels. Each channel has its own FIFO, per-channel enable, flush, level readback and sticky overflow. It sits on the TURFIO Wishbone register space and feeds sysclk-side rackbus encoders through external CDC stream FIFOs. All logic runs on one clock.

---
 rtl/surfturf_cmdq_pkg.sv | 23 ++
 rtl/surfturf_cmdq_if.sv | 31 +++
 rtl/surfturf_cmdq_fifo.sv | 59 +++++
 rtl/surfturf_cmdq_core.sv | 140 ++++++++++++++
 tb/tb_surfturf_cmdq_core.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/surfturf_cmdq_pkg.sv
// rtl/surfturf_cmdq_pkg.sv - register map constants and configuration checks for the command queue
package surfturf_cmdq_pkg;

  // Byte addresses of the register windows
  localparam logic [9:0] CONTROL_ADDR = 10'h000;
  localparam logic [9:0] STATUS_ADDR  = 10'h004;
  localparam logic [9:0] DATA_BASE    = 10'h040;
  localparam logic [9:0] LEVEL_BASE   = 10'h080;

  // Field offsets inside CONTROL and STATUS
  localparam int CONTROL_FLUSH_LSB = 16;
  localparam int STATUS_EMPTY_LSB  = 0;
  localparam int STATUS_FULL_LSB   = 8;
  localparam int STATUS_OVF_LSB    = 16;

  // Legal parameter ranges; checked at elaboration by the top level
  function automatic bit cfg_ok(int num_ch, int data_w, int depth_log2);
    return (num_ch >= 1) && (num_ch <= 8) &&
           (data_w >= 1) && (data_w <= 32) &&
           (depth_log2 >= 1) && (depth_log2 <= 8);
  endfunction

endpackage

// File: rtl/surfturf_cmdq_if.sv
// rtl/surfturf_cmdq_if.sv - Wishbone slave port plus per-channel stream outputs
interface surfturf_cmdq_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);

  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic                     wb_we_i;
  logic [9:0]               wb_adr_i;
  logic [31:0]              wb_dat_i;
  logic [3:0]               wb_sel_i;
  logic                     wb_ack_o;
  logic                     wb_err_o;
  logic                     wb_rty_o;
  logic [31:0]              wb_dat_o;
  logic [NUM_CH*DATA_W-1:0] m_tdata;
  logic [NUM_CH-1:0]        m_tvalid;
  logic [NUM_CH-1:0]        m_tready;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, m_tready,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, m_tdata, m_tvalid
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, m_tready,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, m_tdata, m_tvalid
  );

endinterface

// File: rtl/surfturf_cmdq_fifo.sv
// rtl/surfturf_cmdq_fifo.sv - single-clock first-word-fall-through FIFO with flush
module surfturf_cmdq_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Guard against misuse so pointers never overrun even if the caller slips
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  // Storage has no reset; flush only moves pointers, contents stay
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; flush overrides any same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/surfturf_cmdq_core.sv
// rtl/surfturf_cmdq_core.sv - Wishbone-to-stream multi-channel command queue
module surfturf_cmdq_core
  import surfturf_cmdq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  surfturf_cmdq_if.slave bus
);

  localparam int         SEL_BYTES = (DATA_W + 7) / 8;
  localparam logic [4:0] NUM_CH_W  = 5'(NUM_CH);

  if (!cfg_ok(NUM_CH, DATA_W, DEPTH_LOG2)) begin : g_bad_cfg
    $error("surfturf_cmdq_core: parameter out of range");
  end

  logic                     ack_q;
  logic                     err_q;
  logic [31:0]              dat_q;
  logic [31:0]              rd_data;
  logic                     resp;
  logic                     accept;
  logic                     wr_acc;
  logic                     rd_acc;
  logic [3:0]               ch_idx;
  logic                     in_data_win;
  logic                     in_level_win;
  logic                     ctrl_hit;
  logic                     status_hit;
  logic                     sel_ok;
  logic                     reject;
  logic [NUM_CH-1:0]        data_hit;
  logic [NUM_CH-1:0]        level_hit;
  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH-1:0]        flush;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH-1:0]        ovf;
  logic [NUM_CH-1:0]        ovf_set;
  logic [NUM_CH-1:0]        ovf_clr;
  logic [NUM_CH-1:0]        tvalid;
  logic [DEPTH_LOG2:0]      level [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] tdata;
  logic                     unused_bits;

  // One access per strobe: the registered response blocks re-acceptance
  assign resp   = ack_q | err_q;
  assign accept = bus.wb_cyc_i & bus.wb_stb_i & !resp;
  assign wr_acc = accept & bus.wb_we_i;
  assign rd_acc = accept & !bus.wb_we_i;

  assign ch_idx       = bus.wb_adr_i[5:2];
  assign in_data_win  = (bus.wb_adr_i[9:6] == DATA_BASE[9:6])  && ({1'b0, ch_idx} < NUM_CH_W);
  assign in_level_win = (bus.wb_adr_i[9:6] == LEVEL_BASE[9:6]) && ({1'b0, ch_idx} < NUM_CH_W);
  assign ctrl_hit     = (bus.wb_adr_i[9:2] == CONTROL_ADDR[9:2]);
  assign status_hit   = (bus.wb_adr_i[9:2] == STATUS_ADDR[9:2]);

  // A DATA write is refused if the target is full (sampled before any pop) or lanes are missing
  assign sel_ok  = &bus.wb_sel_i[SEL_BYTES-1:0];
  assign reject  = |(data_hit & (full | {NUM_CH{!sel_ok}}));
  assign ovf_set = wr_acc ? (data_hit & full) : '0;
  assign ovf_clr = (wr_acc & status_hit & bus.wb_sel_i[2]) ?
                   bus.wb_dat_i[STATUS_OVF_LSB +: NUM_CH] : '0;

  assign tvalid = enable & ~empty;
  assign pop    = tvalid & bus.m_tready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign data_hit[c]  = in_data_win  & (ch_idx == 4'(c));
    assign level_hit[c] = in_level_win & (ch_idx == 4'(c));
    assign push[c]      = wr_acc & data_hit[c] & !reject;
    assign flush[c]     = wr_acc & ctrl_hit & bus.wb_sel_i[2] &
                          bus.wb_dat_i[CONTROL_FLUSH_LSB + c];

    surfturf_cmdq_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push[c]),
      .push_data (bus.wb_dat_i[DATA_W-1:0]),
      .pop       (pop[c]),
      .flush     (flush[c]),
      .head      (tdata[c*DATA_W +: DATA_W]),
      .level     (level[c]),
      .full      (full[c]),
      .empty     (empty[c])
    );
  end

  // Read mux over the current register state; unmapped and DATA addresses read 0
  always_comb begin
    rd_data = '0;
    if (ctrl_hit) begin
      rd_data[NUM_CH-1:0] = enable;
    end else if (status_hit) begin
      rd_data[STATUS_EMPTY_LSB +: NUM_CH] = empty;
      rd_data[STATUS_FULL_LSB  +: NUM_CH] = full;
      rd_data[STATUS_OVF_LSB   +: NUM_CH] = ovf;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (level_hit[c]) rd_data[DEPTH_LOG2:0] = level[c];
      end
    end
  end

  // Response flags, registered read data, enables and sticky overflow
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      enable <= '0;
      ovf    <= '0;
    end else begin
      ack_q <= accept & !(wr_acc & reject);
      err_q <= wr_acc & reject;
      dat_q <= rd_acc ? rd_data : '0;
      if (wr_acc & ctrl_hit & bus.wb_sel_i[0]) enable <= bus.wb_dat_i[NUM_CH-1:0];
      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

  assign bus.wb_ack_o = ack_q & bus.wb_cyc_i;
  assign bus.wb_err_o = err_q & bus.wb_cyc_i;
  assign bus.wb_rty_o = 1'b0;
  assign bus.wb_dat_o = dat_q;
  assign bus.m_tvalid = tvalid;
  assign bus.m_tdata  = tdata;

  assign unused_bits = ^{bus.wb_adr_i[1:0], bus.wb_dat_i, bus.wb_sel_i};

endmodule

// File: tb/tb_surfturf_cmdq_core.sv
// tb/tb_surfturf_cmdq_core.sv - scoreboard bench for the command queue
module tb_surfturf_cmdq_core;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 4;

  typedef struct {
    logic        err;
    logic        is_rd;
    logic [31:0] rd;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  rsp_t rsp_q[$];
  logic [15:0] sq[$];

  surfturf_cmdq_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_if ();

  surfturf_cmdq_core #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input string tag, input logic [9:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input logic exp_err,
                         input logic [31:0] exp_rd, input logic [NUM_CH-1:0] rdy_pulse);
    rsp_t e;
    logic got;
    rsp_q.push_back('{err: exp_err, is_rd: !we, rd: exp_rd});
    @(negedge clk);
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    bus_if.wb_we_i  = we;
    bus_if.wb_adr_i = adr;
    bus_if.wb_dat_i = dat;
    bus_if.wb_sel_i = sel;
    bus_if.m_tready = bus_if.m_tready | rdy_pulse;
    @(posedge clk);
    #1;
    bus_if.m_tready = bus_if.m_tready & ~rdy_pulse;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus_if.wb_ack_o | bus_if.wb_err_o;
    end
    e = rsp_q.pop_front();
    chk({tag, " ack/err"}, {30'd0, bus_if.wb_ack_o, bus_if.wb_err_o},
        e.err ? 32'd1 : 32'd2);
    if (e.is_rd) chk({tag, " rdata"}, bus_if.wb_dat_o, e.rd);
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [9:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic exp_err);
    wb_xfer(tag, adr, dat, sel, 1'b1, exp_err, 32'd0, '0);
  endtask

  task automatic rd(input string tag, input logic [9:0] adr, input logic [31:0] exp);
    wb_xfer(tag, adr, 32'd0, 4'hF, 1'b0, 1'b0, exp, '0);
  endtask

  initial begin
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_sel_i = '0;
    bus_if.m_tready = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ack", {31'd0, bus_if.wb_ack_o}, 32'd0);
    chk("reset err", {31'd0, bus_if.wb_err_o}, 32'd0);
    chk("reset rty", {31'd0, bus_if.wb_rty_o}, 32'd0);
    chk("reset dat", bus_if.wb_dat_o, 32'd0);
    chk("reset tvalid", {24'd0, bus_if.m_tvalid}, 32'd0);
    rst = 1'b0;
    rd("status empty", 10'h004, 32'h0000_00FF);
    rd("level0 reset", 10'h080, 32'd0);
    rd("control reset", 10'h000, 32'd0);

    // Single push streams straight out on an enabled, ready channel
    wr("enable ch1", 10'h000, 32'h0000_0002, 4'b0001, 1'b0);
    bus_if.m_tready = 8'h02;
    sq.push_back(16'h1234);
    wr("push ch1", 10'h044, 32'h0000_1234, 4'b0011, 1'b0);
    chk("ch1 tvalid N+1", {31'd0, bus_if.m_tvalid[1]}, 32'd1);
    chk("ch1 tdata", {16'd0, bus_if.m_tdata[16 +: 16]}, {16'd0, sq.pop_front()});
    @(negedge clk);
    chk("ch1 tvalid N+2", {31'd0, bus_if.m_tvalid[1]}, 32'd0);
    bus_if.m_tready = '0;

    // Fill disabled ch3, then overflow it
    for (int i = 0; i < 16; i++) begin
      sq.push_back(16'h0100 + 16'(i));
      wr("fill ch3", 10'h04C, 32'h0000_0100 + i, 4'b0011, 1'b0);
    end
    chk("ch3 tvalid disabled", {31'd0, bus_if.m_tvalid[3]}, 32'd0);
    rd("level3 full", 10'h08C, 32'd16);
    rd("status full", 10'h004, 32'h0000_08F7);
    wr("push ch3 full", 10'h04C, 32'h0000_0DEAD, 4'b0011, 1'b1);
    rd("status ovf", 10'h004, 32'h0008_08F7);
    wr("clear ovf", 10'h004, 32'h0008_0000, 4'b0100, 1'b0);
    rd("status ovf clr", 10'h004, 32'h0000_08F7);

    // Full FIFO with a same-cycle pop still rejects the push
    wr("enable ch1 ch3", 10'h000, 32'h0000_000A, 4'b0001, 1'b0);
    chk("ch3 tvalid", {31'd0, bus_if.m_tvalid[3]}, 32'd1);
    chk("ch3 head pre", {16'd0, bus_if.m_tdata[48 +: 16]}, {16'd0, sq.pop_front()});
    wb_xfer("push full+pop", 10'h04C, 32'h0000_0999, 4'b0011, 1'b1, 1'b1, 32'd0, 8'h08);
    chk("ch3 head post", {16'd0, bus_if.m_tdata[48 +: 16]}, {16'd0, sq[0]});
    rd("level3 after pop", 10'h08C, 32'd15);
    rd("status after pop", 10'h004, 32'h0008_00F7);
    wr("clear ovf 2", 10'h004, 32'h0008_0000, 4'b0100, 1'b0);

    // Flush ch0 and ch2 while leaving enables alone
    for (int i = 0; i < 3; i++) begin
      wr("push ch0", 10'h040, 32'h0000_0A00 + i, 4'b0011, 1'b0);
      wr("push ch2", 10'h048, 32'h0000_0B00 + i, 4'b0011, 1'b0);
    end
    rd("level0 pre flush", 10'h080, 32'd3);
    rd("level2 pre flush", 10'h088, 32'd3);
    wr("flush ch0 ch2", 10'h000, 32'h0005_0000, 4'b0100, 1'b0);
    rd("level0 flushed", 10'h080, 32'd0);
    rd("level2 flushed", 10'h088, 32'd0);
    rd("status flushed", 10'h004, 32'h0000_00F7);
    rd("control after flush", 10'h000, 32'h0000_000A);

    // Missing byte lanes, unmapped and write-only addresses
    wr("push bad sel", 10'h040, 32'h0000_0055, 4'b0001, 1'b1);
    rd("level0 bad sel", 10'h080, 32'd0);
    rd("status bad sel", 10'h004, 32'h0000_00F7);
    rd("read unmapped", 10'h3FC, 32'd0);
    wr("write unmapped", 10'h3FC, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd("read data reg", 10'h04C, 32'd0);
    rd("control final", 10'h000, 32'h0000_000A);
    rd("level3 final", 10'h08C, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
